// File: rtl/trig_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trig_capture_pkg
// Description : Shared FSM state encoding for the triggered capture buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package trig_capture_pkg;

    localparam int STATE_W = 3;

    // Encodings are visible through the status register, keep them stable.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dpram_1w1r.sv
`default_nettype none
// ============================================================================
// Module      : dpram_1w1r
// Description : One write port, one registered read port; read returns old
//               data when both ports address the same word in a cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_1w1r #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/trig_capture_buf.sv
`default_nettype none
// ============================================================================
// Module      : trig_capture_buf
// Description : Armed circular capture of the washout stream; freezes a
//               2**AW sample window around a gated trigger for host readback.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_capture_buf
    import trig_capture_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] a_data,
    input  logic                 a_gate,
    input  logic                 a_trig,
    input  logic                 arm,
    input  logic [AW-1:0]        pretrig,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [DW-1:0] rd_data,
    output logic                 done,
    output logic                 busy,
    output logic                 trig_early,
    output logic [STATE_W-1:0]   state
);

    localparam logic [AW:0]   c_DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_PRE_MAX = '1;

    state_t        r_state;
    state_t        w_state_n;
    logic [AW-1:0] r_wptr,  w_wptr_n;
    logic [AW-1:0] r_start, w_start_n;
    logic [AW-1:0] r_pre,   w_pre_n;
    logic [AW:0]   r_cnt,   w_cnt_n;
    logic [AW:0]   w_cnt_inc;
    logic          r_early, w_early_n;
    logic          r_done,  r_busy;
    logic          w_we;
    logic [AW-1:0] w_raddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    assign w_cnt_inc = r_cnt + c_ONE;

    always_comb begin
        w_state_n = r_state;
        w_we      = 1'b0;
        w_cnt_n   = r_cnt;
        w_pre_n   = r_pre;
        w_start_n = r_start;
        w_early_n = r_early;
        if (arm) begin
            // pretrig is AW bits wide, so it never exceeds depth-1.
            w_pre_n   = pretrig;
            w_cnt_n   = '0;
            w_early_n = 1'b0;
            w_state_n = (pretrig == '0) ? ST_WAIT : ST_PRE;
        end else begin
            unique case (r_state)
                ST_PRE: begin
                    if (a_gate) begin
                        w_we    = 1'b1;
                        w_cnt_n = w_cnt_inc;
                        if (a_trig) begin
                            w_early_n = 1'b1;
                        end
                        if (w_cnt_inc == {1'b0, r_pre}) begin
                            w_state_n = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (a_gate) begin
                        w_we = 1'b1;
                        if (a_trig) begin
                            w_start_n = r_wptr - r_pre;
                            w_cnt_n   = c_ONE;
                            w_state_n = (r_pre == c_PRE_MAX) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (a_gate) begin
                        w_we    = 1'b1;
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == (c_DEPTH - {1'b0, r_pre})) begin
                            w_state_n = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        w_wptr_n = w_we ? (r_wptr + {{(AW-1){1'b0}}, 1'b1}) : r_wptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_start <= '0;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_early <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_n;
            r_start <= w_start_n;
            r_pre   <= w_pre_n;
            r_cnt   <= w_cnt_n;
            r_early <= w_early_n;
            r_done  <= (w_state_n == ST_DONE);
            r_busy  <= (w_state_n == ST_PRE) || (w_state_n == ST_WAIT) ||
                       (w_state_n == ST_POST);
        end
    end

    // Window-relative address; wraps naturally at AW bits.
    assign w_raddr = r_start + rd_addr;

    dpram_1w1r #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (w_we),
        .waddr(r_wptr),
        .wdata(a_data),
        .raddr(w_raddr),
        .rdata(rd_data)
    );

    assign done       = r_done;
    assign busy       = r_busy;
    assign trig_early = r_early;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_trig_capture_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_trig_capture_buf
// Description : Self-checking bench for trig_capture_buf against a sample
//               history model of the capture window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_capture_buf;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] a_data = '0;
    logic                 a_gate = 1'b0;
    logic                 a_trig = 1'b0;
    logic                 arm = 1'b0;
    logic [AW-1:0]        pretrig = '0;
    logic [AW-1:0]        rd_addr = '0;
    logic signed [DW-1:0] rd_data;
    logic                 done;
    logic                 busy;
    logic                 trig_early;
    logic [2:0]           state;

    int errors = 0;
    int checks = 0;

    // Reference model: every gated sample since the last arm, plus the
    // index of the accepted trigger within that history.
    logic [DW-1:0] hist[$];
    int            m_pre   = 0;
    int            m_trig  = -1;
    bit            m_done  = 0;
    bit            m_early = 0;
    bit            m_active = 0;

    trig_capture_buf #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_data    (a_data),
        .a_gate    (a_gate),
        .a_trig    (a_trig),
        .arm       (arm),
        .pretrig   (pretrig),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .done      (done),
        .busy      (busy),
        .trig_early(trig_early),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_state();
        if (m_done)                return 3'd4;
        if (!m_active)             return 3'd0;
        if (m_trig >= 0)           return 3'd3;
        if (hist.size() < m_pre)   return 3'd1;
        return 3'd2;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int k);
        return hist[m_trig - m_pre + k];
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, then settle.
    task automatic step(input logic g, input logic t, input logic ar,
                        input logic [DW-1:0] d, input logic [AW-1:0] pt);
        int idx;
        a_gate = g; a_trig = t; arm = ar; a_data = d; pretrig = pt;
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_done = 0; m_early = 0; m_trig = -1;
        end else if (ar) begin
            hist.delete();
            m_pre = int'(pt); m_trig = -1; m_done = 0; m_early = 0; m_active = 1;
        end else if (m_active && g) begin
            hist.push_back(d);
            idx = hist.size() - 1;
            if (m_trig < 0 && t) begin
                if (idx < m_pre) m_early = 1;
                else             m_trig = idx;
            end
            if (m_trig >= 0 && (idx - m_trig + 1) == (DEPTH - m_pre)) begin
                m_done = 1; m_active = 0;
            end
        end
        #1;
        a_trig = 1'b0; arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (trig_early !== 1'b0) begin errors++; $display("FAIL reset_early: got %b expected 0", trig_early); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        step(1, 0, 1, 16'd0, 4'd4);
        for (int v = 1; v <= 31; v++) begin
            step(1, v == 20, 0, DW'(v), '0);
            if (v == 20) begin
                checks++; if (state !== 3'd3) begin errors++; $display("FAIL ramp_post: got %0d expected 3", state); end
            end
            if (v == 30) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL ramp_done_early: got %b expected 0", done); end
            end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ramp_done: got done=%b busy=%b expected 1/0", done, busy); end
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = AW'(k);
            step(0, 0, 0, '0, '0);
            checks++; if (rd_data !== DW'(k + 16) || rd_data !== exp_word(k)) begin
                errors++; $display("FAIL ramp_read[%0d]: got %0d expected %0d", k, rd_data, k + 16);
            end
        end
    endtask

    task automatic test_pretrig0();
        step(1, 0, 1, 16'd0, 4'd0);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL p0_wait: got %0d expected 2", state); end
        for (int v = 0; v < 16; v++) begin
            step(1, v == 0, 0, DW'(100 + v), '0);
            if (v == 14) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL p0_done_early: got %b expected 0", done); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL p0_done: got %b expected 1", done); end
        rd_addr = '0;
        step(0, 0, 0, '0, '0);
        checks++; if (rd_data !== 16'sd100) begin errors++; $display("FAIL p0_read0: got %0d expected 100", rd_data); end
    endtask

    task automatic test_early();
        int v;
        step(1, 0, 1, 16'd0, 4'd4);
        step(1, 0, 0, 16'd1, '0);
        step(1, 1, 0, 16'd2, '0);
        checks++; if (trig_early !== 1'b1 || state !== 3'd1) begin
            errors++; $display("FAIL early_flag: got early=%b state=%0d expected 1/1", trig_early, state);
        end
        step(1, 0, 0, 16'd3, '0);
        step(1, 0, 0, 16'd4, '0);
        checks++; if (state !== 3'd2 || trig_early !== 1'b1) begin
            errors++; $display("FAIL early_wait: got state=%0d early=%b expected 2/1", state, trig_early);
        end
        v = 5;
        while (!m_done && v < 200) begin
            step(1, v == 50, 0, DW'(v), '0);
            v++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL early_timeout: got done=%b expected 1", done); end
        rd_addr = 4'd4;
        step(0, 0, 0, '0, '0);
        checks++; if (rd_data !== 16'sd50) begin errors++; $display("FAIL early_read4: got %0d expected 50", rd_data); end
    endtask

    task automatic test_gate();
        int v, c;
        step(1, 0, 1, 16'd0, 4'd4);
        v = 1; c = 0;
        while (!m_done && c < 200) begin
            if (c % 2 == 0) begin
                step(1, v == 20, 0, DW'(v), '0);
                v++;
            end else begin
                step(0, v == 10, 0, 16'hDEAD, '0);
            end
            c++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gate_timeout: got done=%b expected 1", done); end
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = AW'(k);
            step(0, 0, 0, '0, '0);
            checks++; if (rd_data !== DW'(k + 16) || rd_data !== exp_word(k)) begin
                errors++; $display("FAIL gate_read[%0d]: got %0d expected %0d", k, rd_data, k + 16);
            end
        end
    endtask

    task automatic test_arm_in_post();
        int v;
        step(1, 0, 1, 16'd0, 4'd4);
        for (v = 1; v <= 10; v++) step(1, v == 6, 0, DW'(v), '0);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL rearm_pre_post: got %0d expected 3", state); end
        step(1, 1, 1, 16'd11, 4'd4);
        checks++; if (state !== 3'd1 || done !== 1'b0 || busy !== 1'b1 || trig_early !== 1'b0) begin
            errors++; $display("FAIL rearm: got state=%0d done=%b busy=%b early=%b expected 1/0/1/0", state, done, busy, trig_early);
        end
        v = 12;
        while (!m_done && v < 200) begin
            step(1, v == 30, 0, DW'(v), '0);
            v++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rearm_timeout: got done=%b expected 1", done); end
        rd_addr = 4'd4;
        step(0, 0, 0, '0, '0);
        checks++; if (rd_data !== 16'sd30) begin errors++; $display("FAIL rearm_read4: got %0d expected 30", rd_data); end
        rd_addr = 4'd0;
        step(0, 0, 0, '0, '0);
        checks++; if (rd_data !== 16'sd26) begin errors++; $display("FAIL rearm_read0: got %0d expected 26", rd_data); end
    endtask

    task automatic test_rst_mid();
        int v;
        step(1, 0, 1, 16'd0, 4'd2);
        for (v = 1; v <= 8; v++) step(1, v == 5, 0, DW'(v), '0);
        rst = 1'b1;
        step(1, 0, 0, 16'd9, '0);
        rst = 1'b0;
        checks++; if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got state=%0d done=%b busy=%b expected 0/0/0", state, done, busy);
        end
        step(1, 0, 1, 16'd0, 4'd2);
        v = 200;
        while (!m_done && v < 400) begin
            step(1, v == 210, 0, DW'(v), '0);
            v++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_timeout: got done=%b expected 1", done); end
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = AW'(k);
            step(0, 0, 0, '0, '0);
            checks++; if (rd_data !== DW'(208 + k)) begin
                errors++; $display("FAIL rst_read[%0d]: got %0d expected %0d", k, rd_data, 208 + k);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        logic [AW-1:0] pt;
        for (int it = 0; it < 8; it++) begin
            pt = AW'($urandom_range(0, DEPTH - 1));
            step(1, 0, 1, DW'($urandom), pt);
            cyc = 0;
            while (!m_done && cyc < 400) begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0, DW'($urandom), '0);
                checks++; if (state !== m_state() || done !== m_done || busy !== (m_active && !m_done) || trig_early !== m_early) begin
                    errors++; $display("FAIL rand_status it=%0d cyc=%0d: got st=%0d d=%b b=%b e=%b expected st=%0d d=%b b=%b e=%b",
                        it, cyc, state, done, busy, trig_early, m_state(), m_done, m_active && !m_done, m_early);
                end
                cyc++;
            end
            checks++; if (!m_done) begin errors++; $display("FAIL rand_timeout it=%0d: got done=%b expected 1", it, done); end
            if (m_done) begin
                for (int k = 0; k < DEPTH; k++) begin
                    rd_addr = AW'(k);
                    step(0, 0, 0, '0, '0);
                    checks++; if (rd_data !== exp_word(k)) begin
                        errors++; $display("FAIL rand_read it=%0d [%0d]: got %0h expected %0h", it, k, rd_data, exp_word(k));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_pretrig0();
        test_early();
        test_gate();
        test_arm_in_post();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/trig_capture_buf.md
Name: trig_capture_buf

Overview:
- Triggered waveform snapshot buffer directly downstream of the ADC washout (DC-reject) stage.
- Consumes the filtered a_data/a_gate/a_trig stream and continuously records it into a circular RAM once armed.
- Freezes a window of 2**aw samples around the trigger: pretrig samples before it, the trigger sample, and the rest after it.
- Host reads the frozen window through a trigger-aligned read port.

Parameters:
dw, 16, sample width (matches washout output width)
aw, 10, RAM address width; window depth = 2**aw samples

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
a_data  input  dw  signed filtered ADC sample
a_gate  input  1  sample valid; only gated samples are written or counted
a_trig  input  1  trigger, qualified by a_gate
arm  input  1  single-cycle pulse; (re)starts a capture
pretrig  input  aw  requested pre-trigger samples, latched on arm
rd_addr  input  aw  window-relative read address; 0 = oldest sample in window
rd_data  output  dw  sample at rd_addr, one cycle latency
done  output  1  window frozen and readable
busy  output  1  capture in progress (PRE, WAIT or POST)
trig_early  output  1  a_trig seen during PRE; sticky until next arm
state  output  3  FSM state for debug/status register

Behaviour:
- Reset values: state=IDLE, wptr=0, counters=0, start_ptr=0, done=0, busy=0, trig_early=0, rd_data=0.
- Clock and reset: clk, with rst synchronous, active-high.
- FSM states: IDLE, PRE, WAIT, POST, DONE. Codes are package constants, 0..4.
- arm, from any state: pre_lat <= min(pretrig, 2**aw-1), cnt <= 0, done <= 0, trig_early <= 0. Next state is PRE, or WAIT if pretrig==0. wptr is not reset.
- arm takes priority over a_trig and over every transition in the same cycle.
- PRE:
  - Each gated sample: mem[wptr] <= a_data, wptr++ (wraps mod 2**aw), cnt++.
  - When the write makes cnt==pre_lat, go to WAIT.
  - a_trig in PRE sets trig_early; the trigger is otherwise ignored.
- WAIT:
  - Gated samples are written continuously and overwrite the oldest data.
  - a_trig&a_gate: the trigger sample is written at wptr, start_ptr <= wptr-pre_lat (mod 2**aw), cnt <= 1, go to POST.
  - If the trigger coincides with post count depth-pre_lat == 1 (pre_lat==2**aw-1), go straight to DONE.
- POST:
  - Gated samples are written, cnt++.
  - When the write makes cnt==2**aw-pre_lat, go to DONE the next cycle.
  - a_trig is ignored.
- DONE: no writes, done=1. Holds until the next arm.
- IDLE: no writes, busy=0.
- busy = (state==PRE)|(state==WAIT)|(state==POST), registered with state.
- Read port:
  - rd_data <= mem[start_ptr+rd_addr], sum mod 2**aw. Registered, one-cycle latency, valid in every state.
  - Contents are guaranteed coherent only while done=1.
  - Simultaneous read and write to the same physical address returns old data.
- a_gate low: no write, no count, no trigger. Washout currently ties gate high, but the block must honour it.
- rst mid-capture: returns to IDLE next cycle. RAM contents are not cleared.
- Window content: window index pre_lat is exactly the trigger sample. Indices 0..pre_lat-1 are the pre_lat gated samples immediately preceding it.

Decomposition:
- Package trig_capture_pkg holds the FSM state constants and the state width (3).
- Sub-module dpram_1w1r: depth 2**aw, width dw, one write port, one registered read port, read-old-on-collision.
- All other logic stays in the top level.

Test Plan:
- aw=4, pretrig=4, a_data=ramp 0,1,2… with gate high; arm at sample 0, a_trig at sample 20 -> done after sample 31. Reads at rd_addr 0..15 return 16..31, one cycle after each address.
- pretrig=0, arm, a_trig on the first sample after arm (value 100) -> rd_addr 0 returns 100; done after 16 gated samples.
- pretrig=4, a_trig at the 2nd sample after arm -> trig_early=1, state stays PRE then WAIT. A later trigger at value 50 -> rd_addr 4 returns 50.
- a_gate toggling 1,0,1,0… with a ramp that advances only on gate -> window identical to the all-gate-high case. A trigger with gate=0 is ignored.
- arm and a_trig in the same cycle during POST -> capture restarts in PRE, done=0, the previous trigger is discarded.
- rst asserted mid-POST -> next cycle state=IDLE, done=0, busy=0. A subsequent arm/trigger sequence captures correctly.
